// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream input and instruction-memory write port of the loader.
interface inst_loader_if #(parameter int ADDR_W = 6);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_cnt;
    logic              err;
    modport slave (input start, in_data, in_valid, in_last,
                   output in_ready, wea, addra, dina, busy, done, word_cnt, err);
    modport master (output start, in_data, in_valid, in_last,
                    input in_ready, wea, addra, dina, busy, done, word_cnt, err);
endinterface

// File: rtl/inst_loader.sv
// inst_loader: packs a byte stream MSB-first into 32-bit words and writes them to instruction memory.
// Defining INST_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte checked after the last word.
module inst_loader #(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 64
) (
    input logic          clka,
    input logic          rst,
    inst_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t FIN = CKSUM;
`else
    localparam state_t FIN = DONE;
`endif
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
    state_t            state, nxt;
    logic [1:0]        idx;
    logic              last_q, err_q, in_rdy, trunc;
    logic [ADDR_W-1:0] addra_q;
    logic [31:0]       dina_q;
    logic [ADDR_W:0]   cnt_q;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
    assign in_rdy = state == LOAD || state == CKSUM;
    assign bus.busy = state == LOAD || state == WRITE || state == CKSUM;
`else
    assign in_rdy = state == LOAD;
    assign bus.busy = state == LOAD || state == WRITE;
`endif
    assign trunc        = cnt_q + 1'b1 == MAX_CNT;
    assign bus.in_ready = in_rdy;
    assign bus.wea      = state == WRITE;
    assign bus.done     = state == DONE;
    assign bus.addra    = addra_q;
    assign bus.dina     = dina_q;
    assign bus.word_cnt = cnt_q;
    assign bus.err      = err_q;
    always_ff @(posedge clka or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = bus.start ? LOAD : state;
            LOAD:       if (bus.in_valid) nxt = idx == 2'd3 ? WRITE : bus.in_last ? DONE : LOAD;
            WRITE:      nxt = (last_q || trunc) ? FIN : LOAD;
`ifdef INST_LOADER_CHECKSUM_EN
            CKSUM:      if (bus.in_valid) nxt = DONE;
`endif
            default:    nxt = IDLE;
        endcase
    end
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            cnt_q   <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    idx   <= '0;
                    err_q <= 1'b0;
                    cnt_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_q <= '0;
`endif
                end
                LOAD: if (bus.in_valid) begin
                    dina_q  <= {dina_q[23:0], bus.in_data};
                    idx     <= idx + 2'd1;
                    last_q  <= bus.in_last;
                    addra_q <= cnt_q[ADDR_W-1:0];
                    if (bus.in_last && idx != 2'd3) err_q <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_q   <= sum_q + bus.in_data;
`endif
                end
                WRITE: begin
                    cnt_q <= cnt_q + 1'b1;
                    idx   <= '0;
                    if (!last_q && trunc) err_q <= 1'b1;
                end
`ifdef INST_LOADER_CHECKSUM_EN
                CKSUM: if (bus.in_valid) err_q <= err_q | (bus.in_data != sum_q);
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed tests of the byte-to-word instruction loader (MAX_WORDS=4).
// Under INST_LOADER_CHECKSUM_EN every load ends with the checksum byte.
module tb_inst_loader;
    logic clka = 1'b0;
    logic rst  = 1'b1;
    int total = 0, bad = 0, cyc = 0;
    logic [7:0]  tb_sum;
    logic [5:0]  wa[$];
    logic [31:0] wd[$];
    logic        wr[$];
    always #5 clka = ~clka;
    inst_loader_if #(.ADDR_W(6)) bus();
    inst_loader #(.ADDR_W(6), .MAX_WORDS(4)) dut (.clka(clka), .rst(rst), .bus(bus));
    always @(posedge clka) begin
        cyc++;
        if (bus.wea === 1'b1) begin
            wa.push_back(bus.addra);
            wd.push_back(bus.dina);
            wr.push_back(bus.in_ready);
        end
    end
    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask
    task automatic pulse_start();
        tb_sum = '0;
        wa.delete(); wd.delete(); wr.delete();
        bus.start = 1'b1;
        @(posedge clka); #1;
        bus.start = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input logic l);
        logic ok;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        bus.in_last  = l;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.in_ready;
            @(posedge clka); #1;
        end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL accept_%h got=%b exp=1", b, ok); end
        else tb_sum = tb_sum + b;
        bus.in_last = 1'b0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 50 && bus.done !== 1'b1; i++) begin @(posedge clka); #1; end
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL done_timeout got=%b exp=1", bus.done); end
    endtask
    task automatic finish_load();
`ifdef INST_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = tb_sum;
        send_byte(s, 1'b0);
`endif
        idle();
        wait_done();
    endtask
    task automatic check_outputs_zero(input string name);
        total++;
        if ({bus.in_ready, bus.wea, bus.busy, bus.done, bus.err} !== 5'b0 || bus.addra !== 6'd0 ||
            bus.dina !== 32'd0 || bus.word_cnt !== 7'd0) begin
            bad++;
            $display("FAIL %s got=rdy%b wea%b busy%b done%b err%b a%h d%h n%0d exp=all zero", name,
                     bus.in_ready, bus.wea, bus.busy, bus.done, bus.err, bus.addra, bus.dina, bus.word_cnt);
        end
    endtask
    task automatic check_writes(input string name, input int n, input logic [31:0] exp_d[4]);
        total++;
        if (wa.size() != n) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, wa.size(), n); end
        for (int i = 0; i < n && i < wa.size(); i++) begin
            total++;
            if (wa[i] !== 6'(i) || wd[i] !== exp_d[i] || wr[i] !== 1'b0) begin
                bad++;
                $display("FAIL %s_w%0d got=a%h d%h rdy%b exp=a%h d%h rdy0", name, i, wa[i], wd[i], wr[i], 6'(i), exp_d[i]);
            end
        end
    endtask
    task automatic check_status(input string name, input logic d, input logic e, input logic [6:0] n);
        total++;
        if (bus.done !== d || bus.err !== e || bus.word_cnt !== n || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s got=done%b err%b n%0d busy%b exp=done%b err%b n%0d busy0", name,
                     bus.done, bus.err, bus.word_cnt, bus.busy, d, e, n);
        end
    endtask
    task automatic test_reset();
        bus.start = 1'b0; bus.in_data = '0;
        idle();
        repeat (2) @(posedge clka);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clka); #1;
        check_outputs_zero("idle");
    endtask
    task automatic test_single();
        logic [31:0] e[4] = '{32'h2001_0005, 0, 0, 0};
        pulse_start();
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL busy_on_start got=%b%b exp=10", bus.busy, bus.done); end
        send_byte(8'h20, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h05, 1);
`ifndef INST_LOADER_CHECKSUM_EN
        idle();
        total++;
        if (bus.wea !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL wea_latency got=wea%b rdy%b exp=wea1 rdy0", bus.wea, bus.in_ready); end
        @(posedge clka); #1;
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL done_latency got=%b exp=1", bus.done); end
`endif
        finish_load();
        check_writes("single", 1, e);
        check_status("single_status", 1, 0, 1);
    endtask
    task automatic test_three_words();
        logic [31:0] e[4] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 0};
        int t0;
        pulse_start();
        t0 = cyc;
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < 4; b++) send_byte(e[w][31-8*b -: 8], w == 2 && b == 3);
`ifndef INST_LOADER_CHECKSUM_EN
        idle();
        wait_done();
        total++;
        if (cyc - t0 != 15) begin bad++; $display("FAIL start_to_done got=%0d exp=15 edges after start edge", cyc - t0); end
`else
        finish_load();
`endif
        check_writes("three", 3, e);
        check_status("three_status", 1, 0, 3);
    endtask
    task automatic test_partial();
        logic [31:0] e[4] = '{0, 0, 0, 0};
        pulse_start();
        send_byte(8'hAA, 0); send_byte(8'hBB, 1);
        idle();
        @(posedge clka); #1;
        check_writes("partial", 0, e);
        check_status("partial_status", 1, 1, 0);
    endtask
    task automatic test_truncate();
        logic [31:0] e[4] = '{32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F};
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        finish_load();
        bus.in_data = 8'hEE; bus.in_valid = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL trunc_ready got=%b exp=0", bus.in_ready); end
        idle();
        check_writes("trunc", 4, e);
        check_status("trunc_status", 1, 1, 4);
    endtask
    task automatic test_abort();
        logic [31:0] e[4] = '{32'hDEAD_BEEF, 0, 0, 0};
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        idle();
        #2 rst = 1'b1;
        #1 check_outputs_zero("abort");
        repeat (2) @(posedge clka);
        #1 rst = 1'b0;
        total++;
        if (wa.size() != 0) begin bad++; $display("FAIL abort_writes got=%0d exp=0", wa.size()); end
        pulse_start();
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 1);
        finish_load();
        check_writes("reload", 1, e);
        check_status("reload_status", 1, 0, 1);
    endtask
`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [7:0] ck, input logic exp_err);
        logic [31:0] e[4] = '{32'h0102_0304, 0, 0, 0};
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
        send_byte(ck, 0);
        idle();
        wait_done();
        check_writes("cksum", 1, e);
        check_status("cksum_status", 1, exp_err, 1);
    endtask
`endif
    initial begin
        test_reset();
        test_single();
        test_three_words();
        test_partial();
        test_truncate();
        test_abort();
`ifdef INST_LOADER_CHECKSUM_EN
        test_checksum(8'h0A, 1'b0);
        test_checksum(8'h0B, 1'b1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
